// File: rtl/arb_mux_reg.sv
// arb_mux_reg: N-channel arbitrating multiplexer with a one-word registered
// output stage (valid/ready on both sides).
//
// Channel selection is either fixed via sel (MODE=0) or round-robin starting
// from an internal pointer (MODE=1). The output register accepts a new word
// whenever it is empty or being drained in the same cycle, so back-to-back
// transfers run at one word per clock.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    NCH*DWIDTH packed channel data, channel i at [i*DWIDTH +: DWIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   sel        fixed channel select (MODE=0 only)
//   out_data   registered selected data
//   out_valid  registered output valid
//   out_ready  downstream ready
//   out_chan   registered index of the channel that supplied out_data

module arb_mux_reg #(
  parameter int DWIDTH = 32,
  parameter int NCH    = 4,
  parameter int MODE   = 0,
  localparam int SELW  = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*DWIDTH-1:0] in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  input  logic [SELW-1:0]       sel,
  output logic [DWIDTH-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SELW-1:0]       out_chan
);

  logic              load;
  logic              grant_ok;
  logic [SELW-1:0]   grant;
  logic [DWIDTH-1:0] grant_data;
  logic              xfer;
  logic [SELW-1:0]   ptr;
  logic [SELW-1:0]   ptr_next;

  // The output register can take a word when empty or draining this cycle.
  assign load = !out_valid || out_ready;

  // Grant selection. In round-robin mode the search runs from the highest
  // offset down so that the lowest offset from ptr (the first valid channel
  // at or after ptr, with wrap) is the one that sticks.
  always_comb begin
    int j;
    j        = 0;
    grant    = '0;
    grant_ok = 1'b0;
    if (MODE == 0) begin
      grant    = sel;
      grant_ok = (int'(sel) < NCH);
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        j = int'(ptr) + k;
        if (j >= NCH) j = j - NCH;
        if (in_valid[j]) begin
          grant    = SELW'(j);
          grant_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = grant_ok && load && (grant == SELW'(i));
      if (grant == SELW'(i)) grant_data = in_data[i*DWIDTH +: DWIDTH];
    end
  end

  // in_ready is one-hot or zero, so any overlap with in_valid is the transfer.
  assign xfer = |(in_ready & in_valid);

  assign ptr_next = (int'(grant) == NCH - 1) ? '0 : grant + SELW'(1);

  // ptr only influences the grant in round-robin mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_chan  <= grant;
        ptr       <= ptr_next;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Testbench for arb_mux_reg: three instances (fixed select NCH=4,
// round-robin NCH=4, fixed select NCH=3) driven by directed scenarios and
// a randomized run checked against a behavioural reference model.

module tb_arb_mux_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // u0: MODE=0, NCH=4
  logic [127:0] d0_in_data;
  logic [3:0]   d0_in_valid, d0_in_ready;
  logic [1:0]   d0_sel, d0_out_chan;
  logic [31:0]  d0_out_data;
  logic         d0_out_valid, d0_out_ready;
  // u1: MODE=1, NCH=4
  logic [127:0] d1_in_data;
  logic [3:0]   d1_in_valid, d1_in_ready;
  logic [1:0]   d1_sel, d1_out_chan;
  logic [31:0]  d1_out_data;
  logic         d1_out_valid, d1_out_ready;
  // u2: MODE=0, NCH=3
  logic [95:0]  d2_in_data;
  logic [2:0]   d2_in_valid, d2_in_ready;
  logic [1:0]   d2_sel, d2_out_chan;
  logic [31:0]  d2_out_data;
  logic         d2_out_valid, d2_out_ready;

  arb_mux_reg #(.DWIDTH(32), .NCH(4), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .in_data(d0_in_data), .in_valid(d0_in_valid),
    .in_ready(d0_in_ready), .sel(d0_sel), .out_data(d0_out_data),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready), .out_chan(d0_out_chan));

  arb_mux_reg #(.DWIDTH(32), .NCH(4), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .in_data(d1_in_data), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .sel(d1_sel), .out_data(d1_out_data),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_chan(d1_out_chan));

  arb_mux_reg #(.DWIDTH(32), .NCH(3), .MODE(0)) u2 (
    .clk(clk), .rst(rst), .in_data(d2_in_data), .in_valid(d2_in_valid),
    .in_ready(d2_in_ready), .sel(d2_sel), .out_data(d2_out_data),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_chan(d2_out_chan));

  // Reference model state
  bit          m0_v, m1_v;
  logic [31:0] m0_d, m1_d;
  int          m0_c, m1_c, m1_ptr;

  // Which channel is offered ready this cycle, and whether a word moves.
  function automatic void model_eval(input int mode, input int nch, input int ptr,
                                     input bit mval, input bit ordy, input int sel,
                                     input logic [15:0] valid, output logic [15:0] rdy,
                                     output int g, output bit xfer);
    bit load;
    int c;
    load = !mval || ordy;
    g    = -1;
    rdy  = '0;
    xfer = 1'b0;
    if (mode == 0) begin
      if (sel < nch) g = sel;
    end else begin
      for (int k = 0; k < nch; k++) begin
        c = (ptr + k) % nch;
        if (g < 0 && valid[c]) g = c;
      end
    end
    if (g >= 0 && load) begin
      rdy[g] = 1'b1;
      xfer   = valid[g];
    end
  endfunction

  task automatic clear_inputs();
    d0_in_data = '0; d0_in_valid = '0; d0_sel = '0; d0_out_ready = 1'b0;
    d1_in_data = '0; d1_in_valid = '0; d1_sel = '0; d1_out_ready = 1'b0;
    d2_in_data = '0; d2_in_valid = '0; d2_sel = '0; d2_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m0_v = 0; m0_d = '0; m0_c = 0;
    m1_v = 0; m1_d = '0; m1_c = 0; m1_ptr = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    d0_sel = 2'd1; d0_in_valid = 4'hF; d1_in_valid = 4'b0110;
    d0_out_ready = 1'b0; d1_out_ready = 1'b0;
    #1;
    tests++;
    if (d0_out_valid !== 1'b0 || d0_out_data !== 32'h0 || d0_out_chan !== 2'd0) begin
      fails++;
      $display("FAIL reset_u0: got v=%b d=%h c=%0d, expected 0/0/0", d0_out_valid, d0_out_data, d0_out_chan);
    end
    tests++;
    if (d1_out_valid !== 1'b0 || d1_out_data !== 32'h0 || d1_out_chan !== 2'd0) begin
      fails++;
      $display("FAIL reset_u1: got v=%b d=%h c=%0d, expected 0/0/0", d1_out_valid, d1_out_data, d1_out_chan);
    end
    tests++;
    if (d2_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_u2: got v=%b, expected 0", d2_out_valid);
    end
    tests++;
    if (d0_in_ready !== 4'b0010) begin
      fails++;
      $display("FAIL reset_ready_u0: got %b, expected 0010", d0_in_ready);
    end
    tests++;
    if (d1_in_ready !== 4'b0010) begin
      fails++;
      $display("FAIL reset_ready_u1: got %b, expected 0010", d1_in_ready);
    end
    @(negedge clk);
    tests++;
    if (d0_out_valid !== 1'b0 || d1_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: got v0=%b v1=%b across an edge, expected 0/0", d0_out_valid, d1_out_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    do_reset();
    for (int i = 0; i < 4; i++) d0_in_data[i*32 +: 32] = $urandom;
    d0_in_data[64 +: 32] = 32'hDEADBEEF;
    d0_sel = 2'd2; d0_in_valid = 4'b0100; d0_out_ready = 1'b1;
    #1;
    tests++;
    if (d0_in_ready !== 4'b0100) begin
      fails++;
      $display("FAIL fixed_ready: got %b, expected 0100", d0_in_ready);
    end
    @(negedge clk);
    tests++;
    if (d0_out_valid !== 1'b1 || d0_out_data !== 32'hDEADBEEF || d0_out_chan !== 2'd2) begin
      fails++;
      $display("FAIL fixed_capture: got v=%b d=%h c=%0d, expected 1/deadbeef/2", d0_out_valid, d0_out_data, d0_out_chan);
    end
  endtask

  task automatic test_rr_all_valid();
    do_reset();
    for (int i = 0; i < 4; i++) d1_in_data[i*32 +: 32] = 32'h1000 + i;
    d1_in_valid = 4'hF; d1_out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      tests++;
      if (d1_out_valid !== 1'b1 || int'(d1_out_chan) != n % 4 || d1_out_data !== 32'h1000 + (n % 4)) begin
        fails++;
        $display("FAIL rr_seq step %0d: got v=%b c=%0d d=%h, expected 1/%0d/%h", n, d1_out_valid, d1_out_chan, d1_out_data, n % 4, 32'h1000 + (n % 4));
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) d1_in_data[i*32 +: 32] = 32'hB000 + i;
    d1_in_valid = 4'b0100; d1_out_ready = 1'b1;
    @(negedge clk);
    d1_in_valid = 4'b0010;
    @(negedge clk);
    tests++;
    if (d1_out_chan !== 2'd1 || d1_out_data !== 32'hB001) begin
      fails++;
      $display("FAIL rr_wrap: got c=%0d d=%h, expected 1/0000b001", d1_out_chan, d1_out_data);
    end
    d1_in_valid = 4'b1110;
    @(negedge clk);
    tests++;
    if (d1_out_chan !== 2'd2) begin
      fails++;
      $display("FAIL rr_ptr_after_wrap: got c=%0d, expected 2", d1_out_chan);
    end
  endtask

  task automatic test_stall();
    do_reset();
    d0_in_data[32 +: 32] = 32'hA5A50001;
    d0_sel = 2'd1; d0_in_valid = 4'hF; d0_out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (d0_out_valid !== 1'b1 || d0_out_data !== 32'hA5A50001 || d0_out_chan !== 2'd1) begin
      fails++;
      $display("FAIL stall_fill: got v=%b d=%h c=%0d, expected 1/a5a50001/1", d0_out_valid, d0_out_data, d0_out_chan);
    end
    d0_out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      d0_sel = 2'($urandom);
      d0_in_valid = 4'($urandom) | 4'b0001;
      for (int i = 0; i < 4; i++) d0_in_data[i*32 +: 32] = $urandom;
      #1;
      tests++;
      if (d0_in_ready !== 4'b0000) begin
        fails++;
        $display("FAIL stall_ready step %0d: got %b, expected 0000", n, d0_in_ready);
      end
      @(negedge clk);
      tests++;
      if (d0_out_valid !== 1'b1 || d0_out_data !== 32'hA5A50001 || d0_out_chan !== 2'd1) begin
        fails++;
        $display("FAIL stall_hold step %0d: got v=%b d=%h c=%0d, expected 1/a5a50001/1", n, d0_out_valid, d0_out_data, d0_out_chan);
      end
    end
    d0_sel = 2'd3; d0_in_valid = 4'b1000; d0_in_data[96 +: 32] = 32'h33333333; d0_out_ready = 1'b1;
    #1;
    tests++;
    if (d0_in_ready !== 4'b1000) begin
      fails++;
      $display("FAIL stall_release_ready: got %b, expected 1000", d0_in_ready);
    end
    @(negedge clk);
    tests++;
    if (d0_out_valid !== 1'b1 || d0_out_data !== 32'h33333333 || d0_out_chan !== 2'd3) begin
      fails++;
      $display("FAIL stall_release: got v=%b d=%h c=%0d, expected 1/33333333/3", d0_out_valid, d0_out_data, d0_out_chan);
    end
  endtask

  task automatic test_bad_sel();
    do_reset();
    d2_in_data = {32'hC2, 32'hC1, 32'hC0};
    d2_sel = 2'd3; d2_in_valid = 3'b111; d2_out_ready = 1'b1;
    #1;
    tests++;
    if (d2_in_ready !== 3'b000) begin
      fails++;
      $display("FAIL bad_sel_ready: got %b, expected 000", d2_in_ready);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      tests++;
      if (d2_out_valid !== 1'b0) begin
        fails++;
        $display("FAIL bad_sel_valid step %0d: got %b, expected 0", n, d2_out_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    d1_in_data[0 +: 32]  = 32'hC0C00000;
    d1_in_data[32 +: 32] = 32'h12345678;
    d1_in_valid = 4'b0010; d1_out_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (d1_out_valid !== 1'b1 || d1_out_data !== 32'h12345678) begin
      fails++;
      $display("FAIL async_fill: got v=%b d=%h, expected 1/12345678", d1_out_valid, d1_out_data);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (d1_out_valid !== 1'b0 || d1_out_data !== 32'h0 || d1_out_chan !== 2'd0) begin
      fails++;
      $display("FAIL async_clear: got v=%b d=%h c=%0d, expected 0/0/0", d1_out_valid, d1_out_data, d1_out_chan);
    end
    tests++;
    if (d1_in_ready !== 4'b0010) begin
      fails++;
      $display("FAIL async_ready: got %b, expected 0010", d1_in_ready);
    end
    d1_in_valid = 4'b0101;
    @(negedge clk);
    rst = 1'b0; d1_out_ready = 1'b1;
    m1_ptr = 0;
    @(negedge clk);
    tests++;
    if (d1_out_valid !== 1'b1 || d1_out_chan !== 2'd0 || d1_out_data !== 32'hC0C00000) begin
      fails++;
      $display("FAIL async_first_grant: got v=%b c=%0d d=%h, expected 1/0/c0c00000", d1_out_valid, d1_out_chan, d1_out_data);
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    int g;
    bit x;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      tests++;
      if (d0_out_valid !== m0_v || d0_out_data !== m0_d || int'(d0_out_chan) != m0_c) begin
        fails++;
        $display("FAIL rand_out_u0 cycle %0d: got v=%b d=%h c=%0d, expected v=%b d=%h c=%0d", n, d0_out_valid, d0_out_data, d0_out_chan, m0_v, m0_d, m0_c);
      end
      tests++;
      if (d1_out_valid !== m1_v || d1_out_data !== m1_d || int'(d1_out_chan) != m1_c) begin
        fails++;
        $display("FAIL rand_out_u1 cycle %0d: got v=%b d=%h c=%0d, expected v=%b d=%h c=%0d", n, d1_out_valid, d1_out_data, d1_out_chan, m1_v, m1_d, m1_c);
      end
      d0_in_valid = 4'($urandom); d0_sel = 2'($urandom);
      d0_out_ready = ($urandom_range(0, 3) != 0);
      d1_in_valid = 4'($urandom) & 4'($urandom); d1_sel = 2'($urandom);
      d1_out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        d0_in_data[i*32 +: 32] = $urandom;
        d1_in_data[i*32 +: 32] = $urandom;
      end
      #1;
      model_eval(0, 4, 0, m0_v, d0_out_ready, int'(d0_sel), {12'b0, d0_in_valid}, r, g, x);
      tests++;
      if (d0_in_ready !== r[3:0]) begin
        fails++;
        $display("FAIL rand_ready_u0 cycle %0d: got %b, expected %b", n, d0_in_ready, r[3:0]);
      end
      if (x) begin
        m0_v = 1; m0_d = d0_in_data[g*32 +: 32]; m0_c = g;
      end else if (m0_v && d0_out_ready) begin
        m0_v = 0;
      end
      model_eval(1, 4, m1_ptr, m1_v, d1_out_ready, 0, {12'b0, d1_in_valid}, r, g, x);
      tests++;
      if (d1_in_ready !== r[3:0]) begin
        fails++;
        $display("FAIL rand_ready_u1 cycle %0d: got %b, expected %b", n, d1_in_ready, r[3:0]);
      end
      if (x) begin
        m1_v = 1; m1_d = d1_in_data[g*32 +: 32]; m1_c = g; m1_ptr = (g + 1) % 4;
      end else if (m1_v && d1_out_ready) begin
        m1_v = 0;
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fixed();
    test_rr_all_valid();
    test_wrap();
    test_stall();
    test_bad_sel();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/arb_mux_reg.md
ARB_MUX_REG -- requirements
Module: arb_mux_reg

Interface
REQ-001 Parameter DWIDTH, default 32, width in bits of each data channel.
REQ-002 Parameter NCH, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter MODE, default 0, where 0 is fixed select via sel and 1 is round-robin arbitration.
REQ-004 Derived SELW = max(1, clog2(NCH)), the width of the channel-index buses.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_data  input  NCH*DWIDTH  packed channel data; channel i occupies bits [i*DWIDTH +: DWIDTH].
REQ-008 in_valid  input  NCH  per-channel valid.
REQ-009 in_ready  output  NCH  per-channel ready, combinational.
REQ-010 sel  input  SELW  channel select; used only when MODE=0.
REQ-011 out_data  output  DWIDTH  registered selected data.
REQ-012 out_valid  output  1  registered output valid.
REQ-013 out_ready  input  1  downstream ready.
REQ-014 out_chan  output  SELW  registered index of the channel that supplied out_data.

Function
REQ-015 load = !out_valid || out_ready; a new word is captured only when load=1.
REQ-016 Input transfer on channel i occurs when in_valid[i] && in_ready[i]; at most one in_ready bit is high in any cycle.
REQ-017 MODE=0: in_ready[i] = load && (i == sel); sel >= NCH drives all in_ready low and grants nothing.
REQ-018 MODE=1: grant goes to the first channel with in_valid set, searching from ptr upward with wrap NCH-1 -> 0; in_ready[grant] = load; all other in_ready bits are 0.
REQ-019 MODE=1: in_ready is all-zero when no in_valid bit is set.
REQ-020 On an input transfer from channel g: out_data <= channel g data, out_chan <= g, and out_valid <= 1 at the next edge (latency 1 cycle).
REQ-021 MODE=1: ptr <= (g+1) mod NCH on each input transfer; ptr holds its value otherwise. ptr is internal, SELW bits wide.
REQ-022 Output transfer occurs when out_valid && out_ready; if there is no simultaneous input transfer, out_valid <= 0 at the next edge.
REQ-023 A simultaneous output and input transfer in the same cycle replaces the output word with no bubble, sustaining 1 word/cycle.
REQ-024 While out_valid && !out_ready: out_data and out_chan are held stable, all in_ready are 0, ptr is held, and changes on sel are ignored.
REQ-025 out_data and out_chan are unchanged whenever no input transfer occurs.

Reset
REQ-026 rst=1 asynchronously forces out_valid=0, out_data=0, out_chan=0 and ptr=0, independent of clk.
REQ-027 Reset mid-transaction discards any held output word; in_ready becomes load-driven immediately (load=1 because out_valid=0).
REQ-028 After rst is released, the first grant follows REQ-017 or REQ-018 starting from ptr=0.

Verification
REQ-029 MODE=0, NCH=4, sel=2, in_valid=4'b0100, ch2=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_chan=2.
REQ-030 MODE=1, all four channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles with no bubble.
REQ-031 MODE=1, ptr=3, only ch1 valid -> grant ch1 (wrap-around), then ptr=2.
REQ-032 out_valid=1, out_ready=0 for 5 cycles while inputs and sel change -> out_data and out_chan constant, in_ready=0; with out_ready=1 -> output transfer plus new capture in the same cycle.
REQ-033 MODE=0, NCH=3, sel=3 with all channels valid -> in_ready=0 and out_valid stays 0.
REQ-034 rst asserted between clock edges while out_valid=1 -> out_valid=0 and out_data=0 immediately; after release, in MODE=1 with ch0 and ch2 valid, the first grant is ch0.
